meta_alu_arbiter: RTL and testbench

META_ALU_ARBITER -- requirements
Module: meta_alu_arbiter

---
 rtl/meta_alu_arbiter_if.sv | 61 ++++++
 rtl/meta_alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_meta_alu_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/meta_alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : meta_alu_arbiter_if
//  Purpose  : Bundle of the requester, ALU and status signals of
//             meta_alu_arbiter. The slave modport is the arbiter's view.
//             The master modport is the view of the surrounding system:
//             the requesters, the ALU and the status consumers.
//  Revision : 1.0 - initial release
// ============================================================================
interface meta_alu_arbiter_if #(
    parameter int META_LEN   = 256,
    parameter int COMP_LEN   = 100,
    parameter int ACTION_LEN = 25
);
    localparam int C_DATA_W = META_LEN + COMP_LEN;

    // Requester 0
    logic [C_DATA_W-1:0]   req0_data_in;
    logic [ACTION_LEN-1:0] req0_action_in;
    logic                  req0_valid_in;
    logic                  req0_ready_out;
    // Requester 1
    logic [C_DATA_W-1:0]   req1_data_in;
    logic [ACTION_LEN-1:0] req1_action_in;
    logic                  req1_valid_in;
    logic                  req1_ready_out;
    // Shared metadata ALU
    logic [C_DATA_W-1:0]   alu_data_out;
    logic [ACTION_LEN-1:0] alu_action_out;
    logic                  alu_valid_out;
    logic [C_DATA_W-1:0]   alu_data_in;
    logic                  alu_valid_in;
    // Response and status
    logic [C_DATA_W-1:0]   rsp_data_out;
    logic                  rsp_id_out;
    logic                  rsp_valid_out;
    logic                  err_timeout_out;
    logic [31:0]           grant_cnt0_out;
    logic [31:0]           grant_cnt1_out;

    modport slave (
        input  req0_data_in, req0_action_in, req0_valid_in,
        input  req1_data_in, req1_action_in, req1_valid_in,
        input  alu_data_in, alu_valid_in,
        output req0_ready_out, req1_ready_out,
        output alu_data_out, alu_action_out, alu_valid_out,
        output rsp_data_out, rsp_id_out, rsp_valid_out,
        output err_timeout_out, grant_cnt0_out, grant_cnt1_out
    );

    modport master (
        output req0_data_in, req0_action_in, req0_valid_in,
        output req1_data_in, req1_action_in, req1_valid_in,
        output alu_data_in, alu_valid_in,
        input  req0_ready_out, req1_ready_out,
        input  alu_data_out, alu_action_out, alu_valid_out,
        input  rsp_data_out, rsp_id_out, rsp_valid_out,
        input  err_timeout_out, grant_cnt0_out, grant_cnt1_out
    );
endinterface
`default_nettype wire

// File: rtl/meta_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : meta_alu_arbiter
//  Purpose  : Round-robin arbiter sharing one metadata ALU between two
//             requesters, one request in flight, with a bounded wait for the
//             ALU result and a sticky timeout flag.
//  Revision : 1.0 - initial release
// ============================================================================
module meta_alu_arbiter #(
    parameter int META_LEN   = 256,
    parameter int COMP_LEN   = 100,
    parameter int ACTION_LEN = 25,
    parameter int TIMEOUT    = 16   // legal range 4..255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    meta_alu_arbiter_if.slave bus
);
    localparam int         C_DATA_W      = META_LEN + COMP_LEN;
    localparam logic [7:0] C_TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q;        // requester granted most recently
    logic                  owner_q;       // requester owning the in-flight op
    logic [C_DATA_W-1:0]   alu_data_q;
    logic [ACTION_LEN-1:0] alu_action_q;
    logic                  alu_valid_q;
    logic [C_DATA_W-1:0]   rsp_data_q;
    logic                  rsp_id_q;
    logic                  rsp_valid_q;
    logic                  err_q;
    logic [7:0]            wait_cnt_q;
    logic [31:0]           grant_cnt0_q;
    logic [31:0]           grant_cnt1_q;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_rsp_take;
    logic                  w_tmo_fire;
    logic [C_DATA_W-1:0]   w_sel_data;
    logic [ACTION_LEN-1:0] w_sel_action;

    // Next-state, arbitration and WAIT-exit decisions
    always_comb begin
        state_d    = state_q;
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        w_rsp_take = 1'b0;
        w_tmo_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes.
                if (bus.req0_valid_in && (!bus.req1_valid_in || last_q)) begin
                    w_grant0 = 1'b1;
                end else if (bus.req1_valid_in) begin
                    w_grant1 = 1'b1;
                end
                if (bus.req0_valid_in || bus.req1_valid_in) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (bus.alu_valid_in) begin
                    w_rsp_take = 1'b1;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == C_TIMEOUT_CNT) begin
                    w_tmo_fire = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_accept     = w_grant0 | w_grant1;
    assign w_sel_data   = w_grant1 ? bus.req1_data_in   : bus.req0_data_in;
    assign w_sel_action = w_grant1 ? bus.req1_action_in : bus.req0_action_in;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture, issue, response, timeout and grant-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;   // makes requester 0 win the first tie
            owner_q      <= 1'b0;
            alu_data_q   <= '0;
            alu_action_q <= '0;
            alu_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            // The issue pulse coincides with the ISSUE state cycle.
            alu_valid_q <= w_accept;
            rsp_valid_q <= w_rsp_take;

            if (w_accept) begin
                alu_data_q   <= w_sel_data;
                alu_action_q <= w_sel_action;
                owner_q      <= w_grant1;
                last_q       <= w_grant1;
            end

            if (w_grant0) begin
                grant_cnt0_q <= grant_cnt0_q + 32'd1;
            end
            if (w_grant1) begin
                grant_cnt1_q <= grant_cnt1_q + 32'd1;
            end

            // Count stops on the exit cycle so TIMEOUT=255 cannot wrap.
            if (state_q == ST_ISSUE) begin
                wait_cnt_q <= '0;
            end else if ((state_q == ST_WAIT) && !w_rsp_take && !w_tmo_fire) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (w_rsp_take) begin
                rsp_data_q <= bus.alu_data_in;
                rsp_id_q   <= owner_q;
            end

            if (w_tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready_out  = w_grant0;
    assign bus.req1_ready_out  = w_grant1;
    assign bus.alu_data_out    = alu_data_q;
    assign bus.alu_action_out  = alu_action_q;
    assign bus.alu_valid_out   = alu_valid_q;
    assign bus.rsp_data_out    = rsp_data_q;
    assign bus.rsp_id_out      = rsp_id_q;
    assign bus.rsp_valid_out   = rsp_valid_q;
    assign bus.err_timeout_out = err_q;
    assign bus.grant_cnt0_out  = grant_cnt0_q;
    assign bus.grant_cnt1_out  = grant_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_meta_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_meta_alu_arbiter
//  Purpose  : Directed, scoreboarded bench for meta_alu_arbiter with a
//             behavioural ALU (result = operand + 1, configurable latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_meta_alu_arbiter;
    localparam int META_LEN   = 256;
    localparam int COMP_LEN   = 100;
    localparam int ACTION_LEN = 25;
    localparam int TIMEOUT    = 16;
    localparam int W          = META_LEN + COMP_LEN;
    localparam int A          = ACTION_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues: expected issues {data,action}, expected responses {id,data}
    logic [W+A-1:0] iss_q[$];
    logic [W:0]     exp_q[$];
    int             rsp_cnt        = 0;
    int             last_issue_cyc = -1;
    int             last_rsp_cyc   = -1;

    // ALU model controls: latency in cycles (0 = never answers), echo pulse
    int alu_delay = 3;
    bit alu_echo  = 1'b0;

    // Directed contention vectors with hand-computed ALU results (+1)
    logic [W-1:0] vd[4];
    logic [W-1:0] ve[4];
    logic [A-1:0] va[4];

    meta_alu_arbiter_if #(
        .META_LEN  (META_LEN),
        .COMP_LEN  (COMP_LEN),
        .ACTION_LEN(ACTION_LEN)
    ) bus ();

    meta_alu_arbiter #(
        .META_LEN  (META_LEN),
        .COMP_LEN  (COMP_LEN),
        .ACTION_LEN(ACTION_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Behavioural ALU: answers alu_delay cycles after the issue cycle
    initial begin : alu_model
        logic [W-1:0] r;
        int           d;
        bit           e;
        bus.alu_valid_in = 1'b0;
        bus.alu_data_in  = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.alu_valid_out === 1'b1 && alu_delay > 0) begin
                r = bus.alu_data_out + 1'b1;
                d = alu_delay;
                e = alu_echo;
                repeat (d) @(posedge clk);
                #1;
                bus.alu_data_in  = r;
                bus.alu_valid_in = 1'b1;
                @(posedge clk); #1;
                bus.alu_valid_in = 1'b0;
                bus.alu_data_in  = '0;
                if (e) begin
                    @(posedge clk); #1;
                    bus.alu_data_in  = ~r;
                    bus.alu_valid_in = 1'b1;
                    @(posedge clk); #1;
                    bus.alu_valid_in = 1'b0;
                    bus.alu_data_in  = '0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues or responds
    initial begin : monitor
        logic [W+A-1:0] ei;
        logic [W:0]     er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.req0_ready_out === 1'b1 || bus.req1_ready_out === 1'b1)
                    chk("ready_exclusive", W'(bus.req0_ready_out & bus.req1_ready_out), '0);
                if (bus.alu_valid_out === 1'b1) begin
                    last_issue_cyc = cyc;
                    if (iss_q.size() == 0) begin
                        fail("unexpected_issue", "got alu_valid_out=1 expected 0");
                    end else begin
                        ei = iss_q.pop_front();
                        chk("issue_data", bus.alu_data_out, ei[W+A-1:A]);
                        chk("issue_action", W'(bus.alu_action_out), W'(ei[A-1:0]));
                    end
                end
                if (bus.rsp_valid_out === 1'b1) begin
                    last_rsp_cyc = cyc;
                    rsp_cnt++;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_rsp", "got rsp_valid_out=1 expected 0");
                    end else begin
                        er = exp_q.pop_front();
                        chk("rsp_id", W'(bus.rsp_id_out), W'(er[W]));
                        chk("rsp_data", bus.rsp_data_out, er[W-1:0]);
                    end
                end
            end
        end
    end

    // Lone request from requester idx; pushes expected issue and (optionally) response
    task automatic send(input int idx, input logic [W-1:0] d, input logic [A-1:0] a,
                        input logic [W-1:0] e, input bit expect_rsp, output int t_acc);
        int  n;
        logic rdy;
        if (idx == 0) begin
            bus.req0_data_in = d; bus.req0_action_in = a; bus.req0_valid_in = 1'b1;
        end else begin
            bus.req1_data_in = d; bus.req1_action_in = a; bus.req1_valid_in = 1'b1;
        end
        n = 0;
        t_acc = -1;
        while (t_acc < 0 && n < 100) begin
            @(negedge clk);
            rdy = (idx == 0) ? bus.req0_ready_out : bus.req1_ready_out;
            if (rdy === 1'b1) begin
                t_acc = cyc;
                iss_q.push_back({d, a});
                if (expect_rsp) exp_q.push_back({idx[0], e});
            end
            n++;
        end
        if (t_acc < 0) fail("accept_timeout", "got no ready within 100 cycles expected acceptance");
        @(posedge clk); #1;
        if (idx == 0) bus.req0_valid_in = 1'b0;
        else          bus.req1_valid_in = 1'b0;
    endtask

    // Both requesters valid continuously for n transactions; order must alternate from req0
    task automatic contend(input int n);
        int got, nw, exp_id, k0, k1;
        k0 = 0;
        k1 = 1;
        bus.req0_data_in = vd[0]; bus.req0_action_in = va[0]; bus.req0_valid_in = 1'b1;
        bus.req1_data_in = vd[1]; bus.req1_action_in = va[1]; bus.req1_valid_in = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_id = k % 2;
            got = -1;
            nw  = 0;
            while (got < 0 && nw < 100) begin
                @(negedge clk);
                if (bus.req0_ready_out === 1'b1)      got = 0;
                else if (bus.req1_ready_out === 1'b1) got = 1;
                nw++;
            end
            if (got < 0) begin
                fail("contend_accept_timeout", "got no ready within 100 cycles expected acceptance");
                break;
            end
            chk("grant_order", W'(got), W'(exp_id));
            if (got == 0) iss_q.push_back({bus.req0_data_in, bus.req0_action_in});
            else          iss_q.push_back({bus.req1_data_in, bus.req1_action_in});
            exp_q.push_back({exp_id[0], ve[k]});
            @(posedge clk); #1;
            if (got == 0) begin
                k0 += 2;
                if (k0 < n) begin bus.req0_data_in = vd[k0]; bus.req0_action_in = va[k0]; end
                else bus.req0_valid_in = 1'b0;
            end else begin
                k1 += 2;
                if (k1 < n) begin bus.req1_data_in = vd[k1]; bus.req1_action_in = va[k1]; end
                else bus.req1_valid_in = 1'b0;
            end
        end
        bus.req0_valid_in = 1'b0;
        bus.req1_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail("rsp_timeout", $sformatf("got %0d responses outstanding expected 0", exp_q.size()));
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero();
        chk("rst_alu_valid",  W'(bus.alu_valid_out), '0);
        chk("rst_rsp_valid",  W'(bus.rsp_valid_out), '0);
        chk("rst_alu_data",   bus.alu_data_out, '0);
        chk("rst_alu_action", W'(bus.alu_action_out), '0);
        chk("rst_rsp_data",   bus.rsp_data_out, '0);
        chk("rst_rsp_id",     W'(bus.rsp_id_out), '0);
        chk("rst_err",        W'(bus.err_timeout_out), '0);
        chk("rst_cnt0",       W'(bus.grant_cnt0_out), '0);
        chk("rst_cnt1",       W'(bus.grant_cnt1_out), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected $finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, t2, terr, snap, n;
        vd[0] = 356'h1234;      ve[0] = 356'h1235;      va[0] = 25'h0000001;
        vd[1] = {4'h9, 344'h0, 8'hFF};
        ve[1] = {4'h9, 336'h0, 16'h0100};               va[1] = 25'h1FFFFFF;
        vd[2] = 356'hFFFF_FFFF; ve[2] = 356'h1_0000_0000; va[2] = 25'h00ABCDE;
        vd[3] = 356'hC0DE;      ve[3] = 356'hC0DF;      va[3] = 25'h1000000;

        bus.req0_data_in = '0; bus.req0_action_in = '0; bus.req0_valid_in = 1'b0;
        bus.req1_data_in = '0; bus.req1_action_in = '0; bus.req1_valid_in = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request, 3-cycle ALU; req1 waiting is accepted on the response cycle
        alu_delay = 3;
        send(0, 356'hA5, 25'h1900000, 356'hA6, 1'b1, t);
        send(1, 356'h3C, 25'h0000042, 356'h3D, 1'b1, t2);
        chk("back_to_back_accept", W'(t2 - t), W'(5));
        wait_drain(40);
        chk("issue_latency_req1", W'(last_issue_cyc - t2), W'(1));
        chk("rsp_latency_req1", W'(last_rsp_cyc - t2), W'(5));
        chk("grant_cnt0_single", W'(bus.grant_cnt0_out), W'(1));
        chk("grant_cnt1_single", W'(bus.grant_cnt1_out), W'(1));

        // Contention after reset: order 0,1,0,1 and two grants each
        do_reset();
        contend(4);
        wait_drain(60);
        chk("grant_cnt0_contend", W'(bus.grant_cnt0_out), W'(2));
        chk("grant_cnt1_contend", W'(bus.grant_cnt1_out), W'(2));

        // Result on the TIMEOUT-th WAIT cycle and on the expiry cycle, then a stale echo in IDLE
        alu_delay = TIMEOUT;
        send(0, 356'h55, 25'h0000055, 356'h56, 1'b1, t);
        wait_drain(TIMEOUT + 20);
        chk("rsp_latency_tmo_m1", W'(last_rsp_cyc - last_issue_cyc), W'(TIMEOUT + 1));
        chk("err_after_boundary", W'(bus.err_timeout_out), '0);
        alu_delay = TIMEOUT + 1;
        alu_echo  = 1'b1;
        send(1, 356'h77, 25'h0000077, 356'h78, 1'b1, t);
        wait_drain(TIMEOUT + 20);
        chk("rsp_latency_expiry", W'(last_rsp_cyc - last_issue_cyc), W'(TIMEOUT + 2));
        chk("err_after_expiry_rsp", W'(bus.err_timeout_out), '0);
        snap = rsp_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("late_result_dropped", W'(rsp_cnt), W'(snap));
        alu_echo = 1'b0;

        // Timeout: ALU silent, flag TIMEOUT+2 cycles after ISSUE, no response
        alu_delay = 0;
        snap = rsp_cnt;
        send(0, 356'h99, 25'h0000099, '0, 1'b0, t);
        terr = -1;
        n = 0;
        while (terr < 0 && n < TIMEOUT + 40) begin
            @(negedge clk);
            if (bus.err_timeout_out === 1'b1) terr = cyc;
            n++;
        end
        if (terr < 0) fail("timeout_flag", "got err_timeout_out=0 expected 1");
        else          chk("timeout_cycle", W'(terr - last_issue_cyc), W'(TIMEOUT + 2));
        @(posedge clk); #1;
        chk("timeout_no_rsp", W'(rsp_cnt), W'(snap));
        alu_delay = 3;
        send(1, 356'hAB, 25'h00000AB, 356'hAC, 1'b1, t);
        wait_drain(40);
        chk("err_sticky", W'(bus.err_timeout_out), W'(1));

        // Reset two cycles after ISSUE; result arriving afterwards is dropped
        alu_delay = 5;
        snap = rsp_cnt;
        send(0, 356'h42, 25'h0000042, '0, 1'b0, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_result_dropped", W'(rsp_cnt), W'(snap));
        alu_delay = 3;
        contend(2);
        wait_drain(40);

        // Grant counter wrap
        force dut.grant_cnt1_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.grant_cnt1_q;
        @(negedge clk);
        chk("cnt1_preload", W'(bus.grant_cnt1_out), W'(32'hFFFF_FFFF));
        @(posedge clk); #1;
        send(1, 356'h5, 25'h0000005, 356'h6, 1'b1, t);
        chk("cnt1_wrap", W'(bus.grant_cnt1_out), '0);
        wait_drain(40);

        chk("issue_queue_empty", W'(iss_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
